// File: rtl/pcie_wr_serializer.sv
// pcie_wr_serializer: buffers hi/lo write-lane pairs from the RX write decoder
// in a FIFO and replays them as single 32-bit write beats (lo lane first) to a
// downstream port that may stall. Entries that arrive while full are dropped whole.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

module pcie_wr_serializer #(
  parameter int ADDR_BITS  = `MEM_ADDR_BITS,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 pcie_clk,
  input  logic                 rst,
  input  logic [1:0]           wr_if_select,
  input  logic [3:0]           wr_mem_select,
  input  logic [ADDR_BITS-1:0] wr_addr_hi,
  input  logic [ADDR_BITS-1:0] wr_addr_lo,
  input  logic [31:0]          wr_data_hi,
  input  logic [31:0]          wr_data_lo,
  input  logic [3:0]           wr_mask_hi,
  input  logic [3:0]           wr_mask_lo,
  input  logic                 wr_en_hi,
  input  logic                 wr_en_lo,
  output logic [1:0]           out_if_select,
  output logic [3:0]           out_mem_select,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [31:0]          out_data,
  output logic [3:0]           out_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 fifo_empty,
  output logic                 stat_wr_drop_inc
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_CNT   = (DEPTH_LOG2+1)'(1);

  // Drain FSM: which lane of the head entry is currently presented.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;

  typedef struct packed {
    logic [1:0]           if_sel;
    logic [3:0]           mem_sel;
    logic [ADDR_BITS-1:0] addr_hi;
    logic [ADDR_BITS-1:0] addr_lo;
    logic [31:0]          data_hi;
    logic [31:0]          data_lo;
    logic [3:0]           mask_hi;
    logic [3:0]           mask_lo;
    logic                 en_hi;
    logic                 en_lo;
  } entry_t;

  entry_t                fifo_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   count;
  logic [1:0]            state;

  entry_t push_entry;
  entry_t head;
  entry_t next_head;
  entry_t ld_entry;
  logic   push_req;
  logic   push_ok;
  logic   accept;
  logic   pop;
  logic   load;
  logic   ld_hi;

  // Assemble the incoming entry and decide whether it fits (a same-cycle pop frees a slot).
  always_comb begin
    push_entry = '{if_sel:  wr_if_select, mem_sel: wr_mem_select,
                   addr_hi: wr_addr_hi,   addr_lo: wr_addr_lo,
                   data_hi: wr_data_hi,   data_lo: wr_data_lo,
                   mask_hi: wr_mask_hi,   mask_lo: wr_mask_lo,
                   en_hi:   wr_en_hi,     en_lo:   wr_en_lo};
    push_req   = wr_en_hi || wr_en_lo;
    push_ok    = push_req && ((count < DEPTH_CNT) || pop);
    rd_ptr_nxt = rd_ptr + DEPTH_LOG2'(1);
    head       = fifo_mem[rd_ptr];
    next_head  = fifo_mem[rd_ptr_nxt];
    accept     = out_valid && out_ready;
    fifo_empty = (count == '0) && !out_valid;
  end

  // Next-beat selection: advance lane or pop head, and preload the next head's first lane.
  always_comb begin
    pop      = 1'b0;
    load     = 1'b0;
    ld_hi    = 1'b0;
    ld_entry = head;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          load  = 1'b1;
          ld_hi = !head.en_lo;
        end
      end
      S_LO: begin
        if (accept) begin
          if (head.en_hi) begin
            load  = 1'b1;
            ld_hi = 1'b1;
          end else begin
            pop = 1'b1;
            if (count > ONE_CNT) begin
              load     = 1'b1;
              ld_entry = next_head;
              ld_hi    = !next_head.en_lo;
            end
          end
        end
      end
      S_HI: begin
        if (accept) begin
          pop = 1'b1;
          if (count > ONE_CNT) begin
            load     = 1'b1;
            ld_entry = next_head;
            ld_hi    = !next_head.en_lo;
          end
        end
      end
      default: ;
    endcase
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge pcie_clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, occupancy and the drop statistic pulse.
  always_ff @(posedge pcie_clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      stat_wr_drop_inc <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)     rd_ptr <= rd_ptr_nxt;
      case ({push_ok, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      stat_wr_drop_inc <= push_req && !push_ok;
    end
  end

  // Registered output beat; held unchanged until the downstream accepts it.
  always_ff @(posedge pcie_clk) begin
    if (rst) begin
      state          <= S_IDLE;
      out_valid      <= 1'b0;
      out_if_select  <= '0;
      out_mem_select <= '0;
      out_addr       <= '0;
      out_data       <= '0;
      out_mask       <= '0;
    end else if (load) begin
      state          <= ld_hi ? S_HI : S_LO;
      out_valid      <= 1'b1;
      out_if_select  <= ld_entry.if_sel;
      out_mem_select <= ld_entry.mem_sel;
      out_addr       <= ld_hi ? ld_entry.addr_hi : ld_entry.addr_lo;
      out_data       <= ld_hi ? ld_entry.data_hi : ld_entry.data_lo;
      out_mask       <= ld_hi ? ld_entry.mask_hi : ld_entry.mask_lo;
    end else if (accept) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcie_wr_serializer.sv
// Bench for pcie_wr_serializer: directed scenarios plus random traffic, checked
// against a beat-queue reference model evaluated on the falling clock edge.
module tb_pcie_wr_serializer;

  localparam int AW = 16;
  localparam int DL = 4;
  localparam int DEPTH = 1 << DL;

  logic          pcie_clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    wr_if_select = '0;
  logic [3:0]    wr_mem_select = '0;
  logic [AW-1:0] wr_addr_hi = '0, wr_addr_lo = '0;
  logic [31:0]   wr_data_hi = '0, wr_data_lo = '0;
  logic [3:0]    wr_mask_hi = '0, wr_mask_lo = '0;
  logic          wr_en_hi = 1'b0, wr_en_lo = 1'b0;
  logic [1:0]    out_if_select;
  logic [3:0]    out_mem_select;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_data;
  logic [3:0]    out_mask;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          fifo_empty;
  logic          stat_wr_drop_inc;

  pcie_wr_serializer #(.ADDR_BITS(AW), .DEPTH_LOG2(DL)) dut (
    .pcie_clk(pcie_clk), .rst(rst),
    .wr_if_select(wr_if_select), .wr_mem_select(wr_mem_select),
    .wr_addr_hi(wr_addr_hi), .wr_addr_lo(wr_addr_lo),
    .wr_data_hi(wr_data_hi), .wr_data_lo(wr_data_lo),
    .wr_mask_hi(wr_mask_hi), .wr_mask_lo(wr_mask_lo),
    .wr_en_hi(wr_en_hi), .wr_en_lo(wr_en_lo),
    .out_if_select(out_if_select), .out_mem_select(out_mem_select),
    .out_addr(out_addr), .out_data(out_data), .out_mask(out_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .fifo_empty(fifo_empty), .stat_wr_drop_inc(stat_wr_drop_inc)
  );

  always #5 pcie_clk = ~pcie_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected beats in issue order; 'last' marks an entry's final beat.
  typedef struct {
    logic [1:0]    ifs;
    logic [3:0]    ms;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    mask;
    bit            last;
  } beat_t;

  beat_t bq[$];
  int    nent = 0;
  bit    exp_drop = 0;
  bit    chk_after_rst = 0;
  bit    prev_stall = 0;
  int    gap = 0;
  int    acc_cnt = 0;
  int    drop_seen = 0;
  logic [63:0] prev_ctl;
  logic [31:0] prev_data;

  // Model step at the falling edge: check present outputs, then predict the next rising edge.
  always @(negedge pcie_clk) begin : model
    beat_t b;
    bit    pop_now;
    if (rst) begin
      bq.delete();
      nent          = 0;
      exp_drop      = 0;
      prev_stall    = 0;
      gap           = 0;
      chk_after_rst = 1;
    end else begin
      if (chk_after_rst) begin
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_empty", 64'(fifo_empty), 64'd1);
        chk("rst_outs", {out_if_select, out_mem_select, out_mask, out_addr, out_data}, 64'd0);
        chk_after_rst = 0;
      end
      chk("fifo_empty", 64'(fifo_empty), 64'((nent == 0) && !out_valid));
      chk("drop_pulse", 64'(stat_wr_drop_inc), 64'(exp_drop));
      if (stat_wr_drop_inc) drop_seen++;
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_ctl", {out_if_select, out_mem_select, out_mask, out_addr}, prev_ctl);
        chk("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (nent > 0 && !out_valid) gap++; else gap = 0;
      if (gap >= 2) chk("valid_gap", 64'(gap), 64'd1);

      pop_now = 0;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (bq.size() == 0) begin
          chk("beat_extra", 64'(out_addr), 64'hDEAD);
        end else begin
          b = bq.pop_front();
          chk("beat_ctl", {out_if_select, out_mem_select, out_mask, out_addr},
              64'({b.ifs, b.ms, b.mask, b.addr}));
          chk("beat_data", 64'(out_data), 64'(b.data));
          pop_now = b.last;
        end
      end

      exp_drop = 0;
      if (wr_en_hi || wr_en_lo) begin
        if (nent < DEPTH || pop_now) begin
          if (wr_en_lo) bq.push_back('{wr_if_select, wr_mem_select, wr_addr_lo, wr_data_lo, wr_mask_lo, !wr_en_hi});
          if (wr_en_hi) bq.push_back('{wr_if_select, wr_mem_select, wr_addr_hi, wr_data_hi, wr_mask_hi, 1'b1});
          nent++;
        end else begin
          exp_drop = 1;
        end
      end
      if (pop_now) nent--;

      prev_stall = out_valid && !out_ready;
      prev_ctl   = {out_if_select, out_mem_select, out_mask, out_addr};
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic rand_fields();
    wr_if_select  = 2'($urandom);
    wr_mem_select = 4'($urandom);
    wr_addr_hi    = AW'($urandom);
    wr_addr_lo    = AW'($urandom);
    wr_data_hi    = $urandom;
    wr_data_lo    = $urandom;
    wr_mask_hi    = 4'($urandom);
    wr_mask_lo    = 4'($urandom);
  endtask

  // One-cycle push of an entry with the given strobes and addresses.
  task automatic push_pair(input logic en_lo, input logic [AW-1:0] a_lo,
                           input logic en_hi, input logic [AW-1:0] a_hi);
    rand_fields();
    wr_en_lo = en_lo; wr_addr_lo = a_lo;
    wr_en_hi = en_hi; wr_addr_hi = a_hi;
    tick();
    wr_en_lo = 1'b0;
    wr_en_hi = 1'b0;
  endtask

  int a0, d0, nv;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Single pair: beats at cycle 2 and 3, then empty.
    push_pair(1'b1, 16'h10, 1'b1, 16'h14);
    @(negedge pcie_clk) chk("t1_c1_valid", 64'(out_valid), 64'd0);
    @(negedge pcie_clk) begin
      chk("t1_c2_valid", 64'(out_valid), 64'd1);
      chk("t1_c2_addr", 64'(out_addr), 64'h10);
    end
    @(negedge pcie_clk) begin
      chk("t1_c3_valid", 64'(out_valid), 64'd1);
      chk("t1_c3_addr", 64'(out_addr), 64'h14);
    end
    @(negedge pcie_clk) chk("t1_empty", 64'(fifo_empty), 64'd1);
    tick();

    // Lane-only writes.
    a0 = acc_cnt;
    push_pair(1'b0, 16'h0, 1'b1, 16'h8);
    repeat (5) tick();
    chk("t2_hi_only_beats", 64'(acc_cnt - a0), 64'd1);
    a0 = acc_cnt;
    push_pair(1'b1, 16'hC, 1'b0, 16'h0);
    repeat (5) tick();
    chk("t2_lo_only_beats", 64'(acc_cnt - a0), 64'd1);

    // Stall with a pending beat.
    out_ready = 1'b0;
    push_pair(1'b1, 16'h20, 1'b1, 16'h24);
    repeat (3) tick();
    repeat (5) tick();
    chk("t3_hold_valid", 64'(out_valid), 64'd1);
    chk("t3_hold_addr", 64'(out_addr), 64'h20);
    a0 = acc_cnt;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("t3_release_beats", 64'(acc_cnt - a0), 64'd2);

    // Overflow: 18 pairs into a 16-deep FIFO while stalled.
    out_ready = 1'b0;
    d0 = drop_seen;
    a0 = acc_cnt;
    for (int i = 0; i < 18; i++) push_pair(1'b1, AW'(i * 8), 1'b1, AW'(i * 8 + 4));
    repeat (3) tick();
    chk("t4_drops", 64'(drop_seen - d0), 64'd2);
    out_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 32; i++) @(negedge pcie_clk) nv += int'(out_valid);
    chk("t4_back_to_back", 64'(nv), 64'd32);
    @(negedge pcie_clk) chk("t4_empty", 64'(fifo_empty), 64'd1);
    tick();
    chk("t4_beats", 64'(acc_cnt - a0), 64'd32);

    // Full FIFO: a push in the cycle the HI lane is accepted is not dropped.
    out_ready = 1'b0;
    d0 = drop_seen;
    a0 = acc_cnt;
    for (int i = 0; i < 16; i++) push_pair(1'b1, AW'(16'h100 + i * 8), 1'b1, AW'(16'h104 + i * 8));
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    push_pair(1'b1, 16'h300, 1'b1, 16'h304);
    repeat (40) tick();
    chk("t5_no_drop", 64'(drop_seen - d0), 64'd0);
    chk("t5_beats", 64'(acc_cnt - a0), 64'd34);

    // Reset mid-burst flushes everything.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_pair(1'b1, AW'(16'h400 + i * 8), 1'b1, AW'(16'h404 + i * 8));
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    a0 = acc_cnt;
    repeat (10) tick();
    chk("t6_no_stale", 64'(acc_cnt - a0), 64'd0);
    chk("t6_empty", 64'(fifo_empty), 64'd1);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 2000; i++) begin
      rand_fields();
      wr_en_lo  = ($urandom_range(0, 9) < 4);
      wr_en_hi  = ($urandom_range(0, 9) < 4);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    wr_en_lo = 1'b0;
    wr_en_hi = 1'b0;
    out_ready = 1'b1;
    repeat (50) tick();
    chk("drain_empty", 64'(fifo_empty), 64'd1);
    chk("drain_model", 64'(bq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
